// File: rtl/dcache_arb_pkg.sv
// rtl/dcache_arb_pkg.sv - shared types and constants for the data-cache memory arbiter
package dcache_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int STRB_WIDTH = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner select
// Ports:
//   req_i  per-requester request vector
//   ptr_i  index of the last served requester; search starts at ptr_i+1
//   idx_o  winning requester index (0 when no request)
//   any_o  at least one request bit is set
module rr_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ID_WIDTH  = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [ID_WIDTH-1:0]  ptr_i,
    output logic [ID_WIDTH-1:0]  idx_o,
    output logic                 any_o
);

    // Walk from the farthest candidate (ptr itself) back to ptr+1 so the
    // last hit, i.e. the nearest set bit after ptr, wins.
    always_comb begin
        idx_o = '0;
        for (int i = NUM_CORES; i >= 1; i--) begin
            if (req_i[(int'(ptr_i) + i) % NUM_CORES]) begin
                idx_o = ID_WIDTH'((int'(ptr_i) + i) % NUM_CORES);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/dcache_mem_arbiter.sv
// rtl/dcache_mem_arbiter.sv - shares one downstream read and one write channel among data caches
// Ports:
//   i_clk, i_rst_n                      clock, synchronous active-low reset
//   i_rd_req/i_rd_addr, o_rd_done/data  per-core line-fill handshake
//   i_wr_valid/addr/data/strobe, o_wr_done  per-core write-through handshake
//   o_mem_read_*, i_mem_read_*          downstream read channel
//   o_mem_write_*, i_mem_write_done     downstream write channel
//   o_snoop_valid/addr/id               completed-write broadcast for LR/SC reservations
module dcache_mem_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int  NUM_CORES       = 4,
    parameter int  ADDR_WIDTH      = 64,
    parameter int  CORE_DATA_WIDTH = 64,
    parameter int  AXI_DATA_WIDTH  = 256,
    localparam int ID_WIDTH        = $clog2(NUM_CORES)
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [NUM_CORES-1:0]                 i_rd_req,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]      i_rd_addr,
    output logic [NUM_CORES-1:0]                 o_rd_done,
    output logic [AXI_DATA_WIDTH-1:0]            o_rd_data,
    input  logic [NUM_CORES-1:0]                 i_wr_valid,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]      i_wr_addr,
    input  logic [NUM_CORES*CORE_DATA_WIDTH-1:0] i_wr_data,
    input  logic [NUM_CORES*STRB_WIDTH-1:0]      i_wr_strobe,
    output logic [NUM_CORES-1:0]                 o_wr_done,
    output logic                                 o_mem_read_req,
    output logic [ADDR_WIDTH-1:0]                o_mem_read_address,
    input  logic                                 i_mem_read_done,
    input  logic [AXI_DATA_WIDTH-1:0]            i_mem_read_data,
    output logic                                 o_mem_write_valid,
    output logic [ADDR_WIDTH-1:0]                o_mem_write_address,
    output logic [CORE_DATA_WIDTH-1:0]           o_mem_write_data,
    output logic [STRB_WIDTH-1:0]                o_mem_write_strobe,
    input  logic                                 i_mem_write_done,
    output logic                                 o_snoop_valid,
    output logic [ADDR_WIDTH-1:0]                o_snoop_addr,
    output logic [ID_WIDTH-1:0]                  o_snoop_id
);

    arb_state_e rd_state_q, rd_state_d, wr_state_q, wr_state_d;
    logic [ID_WIDTH-1:0] rd_grant_q, rd_grant_d, rd_ptr_q, rd_ptr_d;
    logic [ID_WIDTH-1:0] wr_grant_q, wr_grant_d, wr_ptr_q, wr_ptr_d;
    logic [ID_WIDTH-1:0] rd_win, wr_win;
    logic                rd_any, wr_any;
    logic                snoop_valid_q, snoop_valid_d;
    logic [ADDR_WIDTH-1:0] snoop_addr_q, snoop_addr_d;
    logic [ID_WIDTH-1:0]   snoop_id_q, snoop_id_d;
    logic [ADDR_WIDTH-1:0] wr_addr_sel;

    rr_arbiter #(.NUM_CORES(NUM_CORES), .ID_WIDTH(ID_WIDTH)) u_rd_rr (
        .req_i (i_rd_req),
        .ptr_i (rd_ptr_q),
        .idx_o (rd_win),
        .any_o (rd_any)
    );

    rr_arbiter #(.NUM_CORES(NUM_CORES), .ID_WIDTH(ID_WIDTH)) u_wr_rr (
        .req_i (i_wr_valid),
        .ptr_i (wr_ptr_q),
        .idx_o (wr_win),
        .any_o (wr_any)
    );

    assign wr_addr_sel = i_wr_addr[int'(wr_grant_q)*ADDR_WIDTH +: ADDR_WIDTH];

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_state_q    <= IDLE;
            wr_state_q    <= IDLE;
            rd_grant_q    <= '0;
            wr_grant_q    <= '0;
            rd_ptr_q      <= ID_WIDTH'(NUM_CORES - 1);
            wr_ptr_q      <= ID_WIDTH'(NUM_CORES - 1);
            snoop_valid_q <= 1'b0;
            snoop_addr_q  <= '0;
            snoop_id_q    <= '0;
        end else begin
            rd_state_q    <= rd_state_d;
            wr_state_q    <= wr_state_d;
            rd_grant_q    <= rd_grant_d;
            wr_grant_q    <= wr_grant_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            snoop_valid_q <= snoop_valid_d;
            snoop_addr_q  <= snoop_addr_d;
            snoop_id_q    <= snoop_id_d;
        end
    end

    // Next state. The pointer moves only at done, so the served core drops
    // to lowest priority and the FSM spends one IDLE cycle before regranting.
    always_comb begin
        rd_state_d    = rd_state_q;
        rd_grant_d    = rd_grant_q;
        rd_ptr_d      = rd_ptr_q;
        wr_state_d    = wr_state_q;
        wr_grant_d    = wr_grant_q;
        wr_ptr_d      = wr_ptr_q;
        snoop_valid_d = 1'b0;
        snoop_addr_d  = snoop_addr_q;
        snoop_id_d    = snoop_id_q;

        case (rd_state_q)
            IDLE: if (rd_any) begin
                rd_grant_d = rd_win;
                rd_state_d = BUSY;
            end
            BUSY: if (i_mem_read_done) begin
                rd_ptr_d   = rd_grant_q;
                rd_state_d = IDLE;
            end
            default: rd_state_d = IDLE;
        endcase

        case (wr_state_q)
            IDLE: if (wr_any) begin
                wr_grant_d = wr_win;
                wr_state_d = BUSY;
            end
            BUSY: if (i_mem_write_done) begin
                wr_ptr_d      = wr_grant_q;
                wr_state_d    = IDLE;
                snoop_valid_d = 1'b1;
                snoop_addr_d  = wr_addr_sel;
                snoop_id_d    = wr_grant_q;
            end
            default: wr_state_d = IDLE;
        endcase
    end

    // Outputs. Muxed fields are forced to 0 while IDLE; done arriving while
    // IDLE never reaches a core.
    always_comb begin
        o_mem_read_req      = 1'b0;
        o_mem_read_address  = '0;
        o_rd_done           = '0;
        o_rd_data           = '0;
        o_mem_write_valid   = 1'b0;
        o_mem_write_address = '0;
        o_mem_write_data    = '0;
        o_mem_write_strobe  = '0;
        o_wr_done           = '0;

        if (rd_state_q == BUSY) begin
            o_mem_read_req     = i_rd_req[rd_grant_q];
            o_mem_read_address = i_rd_addr[int'(rd_grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
            if (i_mem_read_done) begin
                o_rd_done[rd_grant_q] = 1'b1;
                o_rd_data             = i_mem_read_data;
            end
        end

        if (wr_state_q == BUSY) begin
            o_mem_write_valid   = i_wr_valid[wr_grant_q];
            o_mem_write_address = wr_addr_sel;
            o_mem_write_data    = i_wr_data[int'(wr_grant_q)*CORE_DATA_WIDTH +: CORE_DATA_WIDTH];
            o_mem_write_strobe  = i_wr_strobe[int'(wr_grant_q)*STRB_WIDTH +: STRB_WIDTH];
            if (i_mem_write_done) begin
                o_wr_done[wr_grant_q] = 1'b1;
            end
        end
    end

    assign o_snoop_valid = snoop_valid_q;
    assign o_snoop_addr  = snoop_addr_q;
    assign o_snoop_id    = snoop_id_q;

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// tb/tb_dcache_mem_arbiter.sv - directed self-checking bench for dcache_mem_arbiter
module tb_dcache_mem_arbiter;

    localparam int NC  = 4;
    localparam int AW  = 64;
    localparam int CDW = 64;
    localparam int ADW = 256;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]   rd_req;
    logic [NC*AW-1:0] rd_addr;
    logic [NC-1:0]   rd_done;
    logic [ADW-1:0]  rd_data;
    logic [NC-1:0]   wr_valid;
    logic [NC*AW-1:0] wr_addr;
    logic [NC*CDW-1:0] wr_data;
    logic [NC*8-1:0] wr_strobe;
    logic [NC-1:0]   wr_done;
    logic            mem_read_req;
    logic [AW-1:0]   mem_read_address;
    logic            mem_read_done;
    logic [ADW-1:0]  mem_read_data;
    logic            mem_write_valid;
    logic [AW-1:0]   mem_write_address;
    logic [CDW-1:0]  mem_write_data;
    logic [7:0]      mem_write_strobe;
    logic            mem_write_done;
    logic            snoop_valid;
    logic [AW-1:0]   snoop_addr;
    logic [1:0]      snoop_id;

    int errors = 0;
    int checks = 0;

    localparam logic [ADW-1:0] DATA_A5 = {32{8'hA5}};
    localparam logic [ADW-1:0] DATA_3C = {32{8'h3C}};

    always #5 clk = ~clk;

    dcache_mem_arbiter #(
        .NUM_CORES(NC), .ADDR_WIDTH(AW), .CORE_DATA_WIDTH(CDW), .AXI_DATA_WIDTH(ADW)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_rd_req            (rd_req),
        .i_rd_addr           (rd_addr),
        .o_rd_done           (rd_done),
        .o_rd_data           (rd_data),
        .i_wr_valid          (wr_valid),
        .i_wr_addr           (wr_addr),
        .i_wr_data           (wr_data),
        .i_wr_strobe         (wr_strobe),
        .o_wr_done           (wr_done),
        .o_mem_read_req      (mem_read_req),
        .o_mem_read_address  (mem_read_address),
        .i_mem_read_done     (mem_read_done),
        .i_mem_read_data     (mem_read_data),
        .o_mem_write_valid   (mem_write_valid),
        .o_mem_write_address (mem_write_address),
        .o_mem_write_data    (mem_write_data),
        .o_mem_write_strobe  (mem_write_strobe),
        .i_mem_write_done    (mem_write_done),
        .o_snoop_valid       (snoop_valid),
        .o_snoop_addr        (snoop_addr),
        .o_snoop_id          (snoop_id)
    );

    task automatic chk(input string tag, input logic [ADW-1:0] obs, input logic [ADW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and checks happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Called in the first BUSY cycle of a read for 'core': checks the
    // downstream request, pulses done, then releases the core's request
    // unless keep is set and checks the mandatory idle bubble.
    task automatic read_txn(input string tag, input int core, input logic [AW-1:0] addr,
                            input logic [ADW-1:0] data, input bit keep);
        chk({tag, "_req"}, ADW'(mem_read_req), ADW'(1));
        chk({tag, "_addr"}, ADW'(mem_read_address), ADW'(addr));
        mem_read_done = 1'b1;
        mem_read_data = data;
        settle();
        chk({tag, "_done"}, ADW'(rd_done), ADW'(4'b0001 << core));
        chk({tag, "_data"}, rd_data, data);
        tick();
        mem_read_done = 1'b0;
        mem_read_data = '0;
        if (!keep) rd_req[core] = 1'b0;
        settle();
        chk({tag, "_bubble_req"}, ADW'(mem_read_req), ADW'(0));
        chk({tag, "_bubble_done"}, ADW'(rd_done), ADW'(0));
        chk({tag, "_bubble_data"}, rd_data, '0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rreq"}, ADW'(mem_read_req), ADW'(0));
        chk({tag, "_raddr"}, ADW'(mem_read_address), ADW'(0));
        chk({tag, "_rdone"}, ADW'(rd_done), ADW'(0));
        chk({tag, "_rdata"}, rd_data, '0);
        chk({tag, "_wvalid"}, ADW'(mem_write_valid), ADW'(0));
        chk({tag, "_waddr"}, ADW'(mem_write_address), ADW'(0));
        chk({tag, "_wdata"}, ADW'(mem_write_data), ADW'(0));
        chk({tag, "_wstrb"}, ADW'(mem_write_strobe), ADW'(0));
        chk({tag, "_wdone"}, ADW'(wr_done), ADW'(0));
        chk({tag, "_svalid"}, ADW'(snoop_valid), ADW'(0));
        chk({tag, "_saddr"}, ADW'(snoop_addr), ADW'(0));
        chk({tag, "_sid"}, ADW'(snoop_id), ADW'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        rd_req = '0; rd_addr = '0; wr_valid = '0; wr_addr = '0;
        wr_data = '0; wr_strobe = '0;
        mem_read_done = 1'b0; mem_read_data = '0; mem_write_done = 1'b0;
        tick();
        tick();
        settle();
        check_all_zero("reset");

        // 1: core 2 line fill
        rst_n = 1'b1;
        tick();
        rd_req[2] = 1'b1;
        rd_addr[2*AW +: AW] = 64'h1000;
        settle();
        chk("t1_req_not_yet", ADW'(mem_read_req), ADW'(0));
        tick();
        read_txn("t1", 2, 64'h1000, DATA_A5, 1'b0);

        // 2: fresh reset, cores 0,1,3 together -> order 0,1,3 then 0 again
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rd_addr[0*AW +: AW] = 64'h100;
        rd_addr[1*AW +: AW] = 64'h140;
        rd_addr[3*AW +: AW] = 64'h1C0;
        rd_req = 4'b1011;
        tick();
        read_txn("t2_c0", 0, 64'h100, DATA_3C, 1'b0);
        tick();
        read_txn("t2_c1", 1, 64'h140, DATA_A5, 1'b0);
        tick();
        rd_req[0] = 1'b1;
        read_txn("t2_c3", 3, 64'h1C0, DATA_3C, 1'b0);
        tick();
        read_txn("t2_c0b", 0, 64'h100, DATA_A5, 1'b0);

        // 3: concurrent read (core 1) and write (core 2)
        rd_addr[1*AW +: AW] = 64'h3000;
        rd_req[1] = 1'b1;
        wr_addr[2*AW +: AW] = 64'h4000;
        wr_data[2*CDW +: CDW] = 64'h1111;
        wr_strobe[2*8 +: 8] = 8'hFF;
        wr_valid[2] = 1'b1;
        tick();
        chk("t3_rreq", ADW'(mem_read_req), ADW'(1));
        chk("t3_raddr", ADW'(mem_read_address), ADW'(64'h3000));
        chk("t3_wvalid", ADW'(mem_write_valid), ADW'(1));
        chk("t3_waddr", ADW'(mem_write_address), ADW'(64'h4000));
        mem_write_done = 1'b1;
        settle();
        chk("t3_wdone", ADW'(wr_done), ADW'(4'b0100));
        chk("t3_no_rdone", ADW'(rd_done), ADW'(0));
        chk("t3_snoop_not_yet", ADW'(snoop_valid), ADW'(0));
        tick();
        mem_write_done = 1'b0;
        wr_valid[2] = 1'b0;
        settle();
        chk("t3_snoop_valid", ADW'(snoop_valid), ADW'(1));
        chk("t3_snoop_addr", ADW'(snoop_addr), ADW'(64'h4000));
        chk("t3_snoop_id", ADW'(snoop_id), ADW'(2));
        chk("t3_rreq_still", ADW'(mem_read_req), ADW'(1));
        mem_read_done = 1'b1;
        mem_read_data = DATA_3C;
        settle();
        chk("t3_rdone", ADW'(rd_done), ADW'(4'b0010));
        chk("t3_no_wdone", ADW'(wr_done), ADW'(0));
        tick();
        mem_read_done = 1'b0;
        mem_read_data = '0;
        rd_req[1] = 1'b0;
        settle();
        chk("t3_snoop_one_cycle", ADW'(snoop_valid), ADW'(0));
        chk("t3_snoop_addr_hold", ADW'(snoop_addr), ADW'(64'h4000));

        // 4: core 0 write, downstream fields and snoop
        wr_addr[0*AW +: AW] = 64'h2008;
        wr_data[0*CDW +: CDW] = 64'hDEADBEEF;
        wr_strobe[0*8 +: 8] = 8'h0F;
        wr_valid[0] = 1'b1;
        tick();
        chk("t4_wvalid", ADW'(mem_write_valid), ADW'(1));
        chk("t4_waddr", ADW'(mem_write_address), ADW'(64'h2008));
        chk("t4_wdata", ADW'(mem_write_data), ADW'(64'hDEADBEEF));
        chk("t4_wstrb", ADW'(mem_write_strobe), ADW'(8'h0F));
        mem_write_done = 1'b1;
        settle();
        chk("t4_wdone", ADW'(wr_done), ADW'(4'b0001));
        tick();
        mem_write_done = 1'b0;
        wr_valid[0] = 1'b0;
        settle();
        chk("t4_snoop_valid", ADW'(snoop_valid), ADW'(1));
        chk("t4_snoop_addr", ADW'(snoop_addr), ADW'(64'h2008));
        chk("t4_snoop_id", ADW'(snoop_id), ADW'(0));
        chk("t4_wvalid_bubble", ADW'(mem_write_valid), ADW'(0));
        tick();
        chk("t4_snoop_drop", ADW'(snoop_valid), ADW'(0));
        chk("t4_snoop_id_hold", ADW'(snoop_id), ADW'(0));

        // 5: core 0 streams reads, core 3 must get the next slot
        rd_addr[0*AW +: AW] = 64'h5000;
        rd_addr[3*AW +: AW] = 64'h7000;
        rd_req[0] = 1'b1;
        tick();
        rd_req[3] = 1'b1;
        read_txn("t5_c0", 0, 64'h5000, DATA_A5, 1'b1);
        tick();
        read_txn("t5_c3", 3, 64'h7000, DATA_3C, 1'b0);
        tick();
        chk("t5_c0_again_req", ADW'(mem_read_req), ADW'(1));
        chk("t5_c0_again_addr", ADW'(mem_read_address), ADW'(64'h5000));

        // 6: reset while read BUSY, then a stray done
        rst_n = 1'b0;
        tick();
        check_all_zero("t6_rst");
        rd_req = '0;
        rst_n = 1'b1;
        mem_read_done = 1'b1;
        mem_read_data = DATA_A5;
        settle();
        chk("t6_stray_done", ADW'(rd_done), ADW'(0));
        chk("t6_stray_data", rd_data, '0);
        tick();
        chk("t6_stray_done2", ADW'(rd_done), ADW'(0));
        chk("t6_req_idle", ADW'(mem_read_req), ADW'(0));
        mem_read_done = 1'b0;
        mem_read_data = '0;
        rd_addr[1*AW +: AW] = 64'h9040;
        rd_req[1] = 1'b1;
        tick();
        read_txn("t6_after", 1, 64'h9040, DATA_3C, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
